// File: rtl/cache_victim_ctrl_if.sv
// Miss/writeback/fill/commit signal bundle for the cache victim controller.
// master is the controller side and slave is the pipeline/memory side.
interface cache_victim_ctrl_if #(
    parameter int unsigned TAGW = 20,
    parameter int unsigned IDXW = 5
);
    localparam int unsigned AW = TAGW + IDXW;

    logic              miss_req;
    logic              miss_ready;
    logic [AW-1:0]     miss_addr;
    logic [3:0]        valid_in;
    logic [3:0]        dirty_in;
    logic [4*TAGW-1:0] tags_in;
    logic [3:0]        lru_way;
    logic [3:0]        way_sel;
    logic              wb_valid;
    logic              wb_ready;
    logic [AW-1:0]     wb_addr;
    logic              fill_valid;
    logic              fill_ready;
    logic [AW-1:0]     fill_addr;
    logic              fill_done;
    logic              tag_we;
    logic [3:0]        lru_update;
    logic              lru_enable;
    logic              done;

    modport master (
        input  miss_req, miss_addr, valid_in, dirty_in, tags_in, lru_way,
               wb_ready, fill_ready, fill_done,
        output miss_ready, way_sel, wb_valid, wb_addr, fill_valid, fill_addr,
               tag_we, lru_update, lru_enable, done
    );

    modport slave (
        output miss_req, miss_addr, valid_in, dirty_in, tags_in, lru_way,
               wb_ready, fill_ready, fill_done,
        input  miss_ready, way_sel, wb_valid, wb_addr, fill_valid, fill_addr,
               tag_we, lru_update, lru_enable, done
    );
endinterface

// File: rtl/cache_victim_ctrl.sv
// Miss-handling controller for the 4-way cache. It picks a victim way, runs an
// optional writeback and then the fill, and commits the tag and LRU update.
module cache_victim_ctrl #(
    parameter int unsigned TAGW = 20,
    parameter int unsigned IDXW = 5
) (
    input logic                 clk,
    input logic                 rst,
    cache_victim_ctrl_if.master bus
);
    localparam int unsigned AW = TAGW + IDXW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_FWAIT  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [3:0]      way_sel_q, way_sel_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [AW-1:0]   fill_addr_q, fill_addr_d;
    logic            miss_ready_q, wb_valid_q, fill_valid_q, commit_q;
    logic [3:0]      lru_update_q;

    logic [3:0]      victim_c;
    logic [TAGW-1:0] victim_tag_c;
    logic            victim_dirty_c;
    logic            free_found_c;
    logic            lru_onehot_c;
    logic            accept_c;

    // Victim choice: the lowest free way, otherwise the LRU way. A malformed LRU vector falls back to way 0.
    always_comb begin
        free_found_c   = 1'b0;
        victim_c       = 4'b0001;
        victim_tag_c   = '0;
        lru_onehot_c   = (bus.lru_way != 4'd0) &&
                         ((bus.lru_way & 4'(bus.lru_way - 4'd1)) == 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (!free_found_c && !bus.valid_in[i]) begin
                victim_c     = 4'(4'b0001 << i);
                free_found_c = 1'b1;
            end
        end
        if (!free_found_c) begin
            victim_c = lru_onehot_c ? bus.lru_way : 4'b0001;
        end
        for (int i = 0; i < 4; i++) begin
            if (victim_c[i]) begin
                victim_tag_c = bus.tags_in[i*TAGW +: TAGW];
            end
        end
        victim_dirty_c = |(victim_c & bus.valid_in & bus.dirty_in);
    end

    assign accept_c = bus.miss_req && miss_ready_q && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        way_sel_d   = way_sel_q;
        wb_addr_d   = wb_addr_q;
        fill_addr_d = fill_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    way_sel_d   = victim_c;
                    fill_addr_d = bus.miss_addr;
                    wb_addr_d   = {victim_tag_c, bus.miss_addr[IDXW-1:0]};
                    state_d     = victim_dirty_c ? S_WB : S_FILL;
                end
            end
            S_WB:     if (bus.wb_ready)   state_d = S_FILL;
            S_FILL:   if (bus.fill_ready) state_d = S_FWAIT;
            S_FWAIT:  if (bus.fill_done)  state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so all of them are 0 after a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            way_sel_q    <= '0;
            wb_addr_q    <= '0;
            fill_addr_q  <= '0;
            miss_ready_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            commit_q     <= 1'b0;
            lru_update_q <= '0;
        end else begin
            state_q      <= state_d;
            way_sel_q    <= way_sel_d;
            wb_addr_q    <= wb_addr_d;
            fill_addr_q  <= fill_addr_d;
            miss_ready_q <= (state_d == S_IDLE);
            wb_valid_q   <= (state_d == S_WB);
            fill_valid_q <= (state_d == S_FILL);
            commit_q     <= (state_d == S_COMMIT);
            lru_update_q <= (state_d == S_COMMIT) ? way_sel_d : 4'd0;
        end
    end

    assign bus.miss_ready = miss_ready_q;
    assign bus.way_sel    = way_sel_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.tag_we     = commit_q;
    assign bus.lru_enable = commit_q;
    assign bus.done       = commit_q;
    assign bus.lru_update = lru_update_q;
endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Self-checking bench for cache_victim_ctrl: directed scenarios plus random
// misses checked against a transaction-level reference model.
module tb_cache_victim_ctrl;
    localparam int unsigned TAGW = 20;
    localparam int unsigned IDXW = 5;
    localparam int unsigned AW   = TAGW + IDXW;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cache_victim_ctrl_if #(.TAGW(TAGW), .IDXW(IDXW)) bus ();

    cache_victim_ctrl #(.TAGW(TAGW), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference victim rule: first invalid way, else a well-formed LRU way, else way 0.
    function automatic logic [3:0] ref_victim(input logic [3:0] valid, input logic [3:0] lru);
        for (int i = 0; i < 4; i++) begin
            if (valid[i] == 1'b0) return 4'(1 << i);
        end
        if ($countones(lru) == 1) return lru;
        return 4'b0001;
    endfunction

    function automatic int way_index(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'(|{bus.miss_ready, bus.way_sel, bus.wb_valid, bus.wb_addr, bus.fill_valid,
                     bus.fill_addr, bus.tag_we, bus.lru_update, bus.lru_enable, bus.done});
    endfunction

    // One miss: waits are the number of stall cycles before each ready or done.
    task automatic run_miss(input logic [AW-1:0] addr, input logic [3:0] valid,
                            input logic [3:0] dirty, input logic [4*TAGW-1:0] tags,
                            input logic [3:0] lru, input int wbw, input int fw,
                            input int dw, input bit glitch, input bit hold);
        logic [3:0]    ev;
        bit            ewb;
        logic [AW-1:0] ewba;
        ev   = ref_victim(valid, lru);
        ewb  = (valid & dirty & ev) != 4'd0;
        ewba = {tags[way_index(ev)*TAGW +: TAGW], addr[IDXW-1:0]};

        chk("ready_idle", 64'(bus.miss_ready), 64'(1));
        bus.miss_addr = addr;
        bus.valid_in  = valid;
        bus.dirty_in  = dirty;
        bus.tags_in   = tags;
        bus.lru_way   = lru;
        bus.miss_req  = 1'b1;
        @(negedge clk);
        if (!hold) bus.miss_req = 1'b0;
        bus.valid_in = 4'($urandom);
        bus.dirty_in = 4'($urandom);
        bus.tags_in  = (4*TAGW)'({$urandom, $urandom, $urandom});
        bus.lru_way  = 4'($urandom);

        chk("way_sel", 64'(bus.way_sel), 64'(ev));
        chk("fill_addr", 64'(bus.fill_addr), 64'(addr));
        chk("busy", 64'(bus.miss_ready), 64'(0));
        if (ewb) begin
            chk("wb_addr", 64'(bus.wb_addr), 64'(ewba));
            for (int k = 0; k <= wbw; k++) begin
                chk("wb_valid", 64'(bus.wb_valid), 64'(1));
                chk("wb_no_fill", 64'(bus.fill_valid), 64'(0));
                bus.wb_ready = (k == wbw);
                @(negedge clk);
            end
            bus.wb_ready = 1'b0;
        end
        for (int k = 0; k <= fw; k++) begin
            chk("fill_valid", 64'(bus.fill_valid), 64'(1));
            chk("fill_no_wb", 64'(bus.wb_valid), 64'(0));
            bus.fill_ready = (k == fw);
            bus.fill_done  = glitch && (k == 0);
            @(negedge clk);
        end
        bus.fill_ready = 1'b0;
        bus.fill_done  = 1'b0;
        for (int k = 0; k <= dw; k++) begin
            chk("fwait_no_done", 64'(bus.done), 64'(0));
            chk("fwait_no_fill", 64'(bus.fill_valid), 64'(0));
            if (hold && k == 0) bus.miss_addr = AW'($urandom);
            bus.fill_done = (k == dw);
            @(negedge clk);
        end
        bus.fill_done = 1'b0;
        chk("done", 64'(bus.done), 64'(1));
        chk("tag_we", 64'(bus.tag_we), 64'(1));
        chk("lru_enable", 64'(bus.lru_enable), 64'(1));
        chk("lru_update", 64'(bus.lru_update), 64'(ev));
        chk("commit_fill_addr", 64'(bus.fill_addr), 64'(addr));
        @(negedge clk);
        chk("post_done", 64'(bus.done), 64'(0));
        chk("post_lru_update", 64'(bus.lru_update), 64'(0));
    endtask

    initial begin
        logic [4*TAGW-1:0] tags;
        bus.miss_req   = 1'b0;
        bus.miss_addr  = '0;
        bus.valid_in   = '0;
        bus.dirty_in   = '0;
        bus.tags_in    = '0;
        bus.lru_way    = '0;
        bus.wb_ready   = 1'b0;
        bus.fill_ready = 1'b0;
        bus.fill_done  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        chk("reset_outputs2", all_outputs(), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Invalid way preferred, minimum latency
        tags = (4*TAGW)'({$urandom, $urandom, $urandom});
        run_miss(25'h1ABCDE5, 4'b1011, 4'b1111, tags, 4'b0001, 0, 0, 0, 1'b0, 1'b0);

        // Dirty LRU victim with a stalled writeback
        tags = {20'hF00D1, 20'h11111, 20'h22222, 20'h33333};
        run_miss({20'h54321, 5'h05}, 4'b1111, 4'b1000, tags, 4'b1000, 3, 1, 2, 1'b0, 1'b0);

        // Clean LRU victim skips writeback
        run_miss({20'hABCDE, 5'h11}, 4'b1111, 4'b1000, tags, 4'b0010, 0, 0, 0, 1'b0, 1'b0);

        // Malformed LRU, plus an early fill_done during FILL
        run_miss({20'h0BEEF, 5'h1F}, 4'b1111, 4'b0000, tags, 4'b0110, 0, 1, 2, 1'b1, 1'b0);

        // miss_req held high: back-to-back accepts
        run_miss({20'h10001, 5'h01}, 4'b0000, 4'b0000, tags, 4'b0001, 0, 0, 1, 1'b0, 1'b1);
        run_miss({20'h20002, 5'h02}, 4'b1111, 4'b0100, tags, 4'b0100, 1, 0, 0, 1'b0, 1'b1);
        run_miss({20'h30003, 5'h03}, 4'b1110, 4'b0000, tags, 4'b0100, 0, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of FWAIT
        chk("rst_pre_ready", 64'(bus.miss_ready), 64'(1));
        bus.miss_addr = 25'h0123456;
        bus.valid_in  = 4'b0000;
        bus.miss_req  = 1'b1;
        @(negedge clk);
        bus.miss_req   = 1'b0;
        bus.fill_ready = 1'b1;
        @(negedge clk);
        bus.fill_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        chk("rst_mid_outputs2", all_outputs(), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", 64'(bus.miss_ready), 64'(1));
        chk("rst_after_done", 64'(bus.done), 64'(0));
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        chk("rst_stray_done", 64'(bus.done), 64'(0));
        chk("rst_stray_lru", 64'(bus.lru_enable), 64'(0));
        @(negedge clk);

        // Random misses, LRU vector sometimes malformed
        for (int n = 0; n < 30; n++) begin
            logic [3:0] v, d, l;
            v    = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
            d    = 4'($urandom);
            l    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            tags = (4*TAGW)'({$urandom, $urandom, $urandom});
            run_miss(AW'($urandom), v, d, tags, l, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_victim_ctrl.md
Name: cache_victim_ctrl

Overview:
Miss-handling and replacement controller for the 4-way set-associative M-stage cache. Consumes the one-hot LRU way from the per-set LRU FSM plus the set's valid/dirty/tag state and selects a victim way. Sequences the optional dirty writeback and the line fill through valid/ready handshakes. On completion it emits the tag-write strobe and a one-cycle access update back into the LRU FSM (its LRUin/enable inputs).

Parameters:
TAGW, 20, tag width in bits
IDXW, 5, set-index width in bits (line address = TAGW+IDXW bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_req  in  1  miss present; accepted when miss_req & miss_ready
miss_ready  out  1  controller idle and able to accept a miss
miss_addr  in  TAGW+IDXW  line address of the miss, {tag,index}
valid_in  in  4  per-way valid bits of the indexed set
dirty_in  in  4  per-way dirty bits of the indexed set
tags_in  in  4*TAGW  per-way tags; way i at [i*TAGW +: TAGW]
lru_way  in  4  one-hot LRU way from the LRU FSM
way_sel  out  4  one-hot latched victim way, held until the next accept
wb_valid  out  1  writeback request
wb_ready  in  1  writeback accepted
wb_addr  out  TAGW+IDXW  {victim tag, index}
fill_valid  out  1  fill request
fill_ready  in  1  fill request accepted
fill_addr  out  TAGW+IDXW  latched miss_addr
fill_done  in  1  fill data written into the data array (pulse)
tag_we  out  1  one-cycle tag/valid write for way_sel, clears dirty
lru_update  out  4  one-hot way to the LRU FSM (equals way_sel during COMMIT, else 0)
lru_enable  out  1  one-cycle LRU update strobe
done  out  1  one-cycle miss-complete pulse

Behaviour:
- Synchronous reset only, sampled on the rising clk edge. While rst=1, all outputs are 0, including miss_ready. On the first edge with rst=1: state=IDLE and way_sel/wb_addr/fill_addr regs are cleared to 0. Reset mid-operation abandons the transaction; no done or lru_enable pulse is produced.
- Outputs are Moore, decoded from registered state. Latched regs hold across states.
- States and transitions:
  - IDLE: miss_ready=1. On miss_req=1, latch the following and select the next state:
    - Victim = lowest-index way with valid_in=0. If all four ways are valid, victim = lru_way.
    - If lru_way is not exactly one-hot (0 or multiple bits set) and is needed, victim = way 0 (4'b0001).
    - Latch way_sel, fill_addr=miss_addr, wb_addr={tags_in[victim], miss_addr index}.
    - Go to WB if the victim is valid and dirty, else FILL.
  - WB: wb_valid=1 until a cycle with wb_ready=1, then go to FILL.
  - FILL: fill_valid=1 until a cycle with fill_ready=1, then go to FWAIT.
  - FWAIT: wait for fill_done=1, then go to COMMIT.
  - COMMIT: single cycle with tag_we=1, lru_enable=1, lru_update=way_sel, done=1. Next state IDLE.
- miss_req outside IDLE is ignored. fill_done outside FWAIT is ignored. wb_ready/fill_ready are ignored in other states.
- Minimum latency (clean miss, fill_ready and fill_done immediately high): accept at cycle 0, FILL at 1, FWAIT at 2, COMMIT at 3, miss_ready=1 again at 4.
- A dirty miss adds at least one WB cycle.
- Back-to-back misses: a new accept is possible in the cycle after COMMIT.
- valid_in/dirty_in/tags_in/lru_way are sampled only in the accept cycle. Later changes do not affect the transaction in flight.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-FWAIT. Required: all outputs 0 during reset; after deassert, miss_ready=1 and no done pulse.
- Invalid way preferred: valid_in=4'b1011, lru_way=4'b0001, miss_addr=25'h1ABCDE5. Required: way_sel=4'b0100, no wb_valid, fill_addr=25'h1ABCDE5, COMMIT at cycle 3 with lru_update=4'b0100.
- Dirty LRU victim: valid_in=4'b1111, dirty_in=4'b1000, lru_way=4'b1000, tags_in way3=20'hF00D1, index=5'h05. Required: wb_valid with wb_addr={20'hF00D1,5'h05}; wb_ready held low for 3 cycles keeps wb_valid=1; then the fill proceeds.
- Clean LRU victim: valid_in=4'b1111, dirty_in=4'b1000, lru_way=4'b0010. Required: way_sel=4'b0010, WB skipped, fill_valid in cycle 1.
- Malformed LRU: valid_in=4'b1111, lru_way=4'b0110. Required: way_sel=4'b0001. Also: fill_done pulsed during FILL is ignored; a later fill_done in FWAIT completes the miss.
- Busy rejection: miss_req held high throughout. Required: exactly one transaction per IDLE accept, with the second accepted in the cycle after done; miss_addr changes during FWAIT do not alter fill_addr.
